// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, frame constants, timing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Cycles from start-bit detection to the start-bit mid-point.
    function automatic int half_bit_clks(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_trx_if.sv
// UART endpoint signal bundle: mode/data in, serial lines, receive strobe, busy.
// Latency: n/a (wiring only).
// Backpressure: none; the receive strobe is fire-and-forget.
// master = the side that drives mode, transmit byte and serial input;
// slave  = the UART itself, driving serial output and receive results.
interface uart_trx_if;
    import uart_pkg::*;

    logic                 rw;
    logic [DATA_BITS-1:0] databus;
    logic                 rx_line;
    logic                 tx_line;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 busy;

    modport master (
        output rw, databus, rx_line,
        input  tx_line, rx_data, rx_valid, busy
    );

    modport slave (
        input  rw, databus, rx_line,
        output tx_line, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-timing counter: bit_tick on the last cycle of each bit, mid_tick at the half-bit point.
// Latency: strobes are combinational from the counter register.
// Backpressure: none; clear restarts the bit period on the next edge.
// Ports: clk, reset (async active-low), clear (synchronous restart),
//        bit_tick (bit boundary), mid_tick (half-bit point; never fires when half is 0).
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic mid_tick
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = half_bit_clks(CLKS_PER_BIT);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic          HAS_MID = (HALF > 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);
    assign mid_tick = HAS_MID && (cnt == MID);

endmodule

// File: rtl/uart_trx.sv
// Half-duplex UART: one FSM serves either transmit (rw=0) or receive (rw=1), 8N1 framing.
// Latency: TX frames repeat every 11 bit times; rx_valid strobes on the stop-bit sample.
// Backpressure: none; rx_valid is a single-cycle strobe, TX streams while rw stays 0.
// Ports: clk, reset (async active-low), rw (0=TX,1=RX, sampled in IDLE), databus (TX byte),
//        Rx (serial in, same clock domain), Tx (registered serial out), rx_data, rx_valid, busy.
module uart_trx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] databus,
    input  logic                 Rx,
    output logic                 Tx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    // With one clock per bit the detecting sample is already the start-bit
    // mid-point, so the receiver steps straight from IDLE into DATA.
    localparam logic NO_START_WAIT = (half_bit_clks(CLKS_PER_BIT) == 0);

    state_e               state;
    logic                 rx_mode;
    logic [DATA_BITS-1:0] shreg;
    logic [BCW-1:0]       bit_cnt;
    logic                 baud_clear;
    logic                 bit_tick;
    logic                 mid_tick;

    // Receive timing is anchored to the start-bit edge: the counter is parked
    // while hunting for a start bit, then restarted at the start-bit mid-point
    // so every following bit_tick lands mid-bit. TX lets it free-run.
    assign baud_clear = ((state == IDLE) && rw) ||
                        ((state == START) && rx_mode && mid_tick);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rx_mode  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            Tx       <= STOP_BIT;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Mode is frozen here for the whole frame that follows.
                    rx_mode <= rw;
                    if (rw) begin
                        Tx <= STOP_BIT;
                        if (Rx == START_BIT) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= NO_START_WAIT ? DATA : START;
                        end
                    end else if (bit_tick) begin
                        // End of the idle bit: capture the byte and start the frame.
                        shreg <= databus;
                        Tx    <= START_BIT;
                        state <= START;
                    end
                end

                START: begin
                    if (rx_mode) begin
                        if (mid_tick) begin
                            state <= (Rx == START_BIT) ? DATA : IDLE;
                        end
                    end else if (bit_tick) begin
                        Tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        // Shift right in both modes: TX keeps the bit on the line
                        // in shreg[0], RX fills from the top so bit 0 lands last at [0].
                        if (rx_mode) begin
                            shreg <= {Rx, shreg[DATA_BITS-1:1]};
                        end else begin
                            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                        end
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            if (!rx_mode) begin
                                Tx <= STOP_BIT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!rx_mode) begin
                                Tx <= shreg[1];
                            end
                        end
                    end
                end

                STOP: begin
                    if (bit_tick) begin
                        // A low stop sample is a framing error: the byte is dropped.
                        if (rx_mode && (Rx == STOP_BIT)) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_trx.sv
// Self-checking bench for uart_trx: TX waveform, mode freeze, loopback, RX framing, glitch, reset.
// Latency: n/a (simulation only).
// Backpressure: n/a.
module tb_uart_trx;

    logic clk;
    logic rst_tx;
    logic rst_rx;
    logic rst_rx16;
    logic loop_en;
    logic rx1_in;

    int n_checks;
    int n_errors;

    bit         wave_q[$];
    logic [7:0] obs_q[$];

    uart_trx_if ifc_tx ();
    uart_trx_if ifc_rx ();
    uart_trx_if ifc_rx16 ();

    assign rx1_in = loop_en ? ifc_tx.tx_line : ifc_rx.rx_line;

    uart_trx #(.CLKS_PER_BIT(1)) u_tx1 (
        .clk(clk), .reset(rst_tx), .rw(ifc_tx.rw), .databus(ifc_tx.databus),
        .Rx(ifc_tx.rx_line), .Tx(ifc_tx.tx_line), .rx_data(ifc_tx.rx_data),
        .rx_valid(ifc_tx.rx_valid), .busy(ifc_tx.busy)
    );

    uart_trx #(.CLKS_PER_BIT(1)) u_rx1 (
        .clk(clk), .reset(rst_rx), .rw(ifc_rx.rw), .databus(ifc_rx.databus),
        .Rx(rx1_in), .Tx(ifc_rx.tx_line), .rx_data(ifc_rx.rx_data),
        .rx_valid(ifc_rx.rx_valid), .busy(ifc_rx.busy)
    );

    uart_trx #(.CLKS_PER_BIT(16)) u_rx16 (
        .clk(clk), .reset(rst_rx16), .rw(ifc_rx16.rw), .databus(ifc_rx16.databus),
        .Rx(ifc_rx16.rx_line), .Tx(ifc_rx16.tx_line), .rx_data(ifc_rx16.rx_data),
        .rx_valid(ifc_rx16.rx_valid), .busy(ifc_rx16.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference line level k bit-times into an 11-bit TX period:
    // idle, start, eight data bits LSB first, stop.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k == 0) return 1'b1;
        if (k == 1) return 1'b0;
        if (k <= 9) return b[k-2];
        return 1'b1;
    endfunction

    task automatic append_frame(input logic [7:0] b, input bit stop, input int gap);
        wave_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) wave_q.push_back(b[i]);
        wave_q.push_back(stop);
        for (int i = 0; i < gap; i++) wave_q.push_back(1'b1);
    endtask

    // Plays wave_q onto one receiver, cpb clocks per bit, collecting strobed bytes.
    task automatic drive_wave(input int which, input int cpb);
        foreach (wave_q[i]) begin
            for (int c = 0; c < cpb; c++) begin
                if (which == 0) ifc_rx.rx_line = wave_q[i];
                else            ifc_rx16.rx_line = wave_q[i];
                step();
                if (which == 0) begin
                    if (ifc_rx.rx_valid === 1'b1) obs_q.push_back(ifc_rx.rx_data);
                end else begin
                    if (ifc_rx16.rx_valid === 1'b1) obs_q.push_back(ifc_rx16.rx_data);
                end
            end
        end
        wave_q.delete();
    endtask

    task automatic test_reset();
        rst_tx = 1'b0; rst_rx = 1'b0; rst_rx16 = 1'b0;
        ifc_tx.rw = 1'b0; ifc_tx.databus = 8'h55; ifc_tx.rx_line = 1'b1;
        ifc_rx.rw = 1'b1; ifc_rx.databus = 8'h00; ifc_rx.rx_line = 1'b1;
        ifc_rx16.rw = 1'b1; ifc_rx16.databus = 8'h00; ifc_rx16.rx_line = 1'b1;
        loop_en = 1'b0;
        repeat (3) step();
        n_checks++;
        if (ifc_tx.tx_line !== 1'b1) begin
            n_errors++; $display("FAIL reset_tx got %b expected 1", ifc_tx.tx_line);
        end
        n_checks++;
        if (ifc_tx.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy got %b expected 0", ifc_tx.busy);
        end
        n_checks++;
        if (ifc_tx.rx_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_rx_valid got %b expected 0", ifc_tx.rx_valid);
        end
        n_checks++;
        if (ifc_tx.rx_data !== 8'h00) begin
            n_errors++; $display("FAIL reset_rx_data got %h expected 00", ifc_tx.rx_data);
        end
        n_checks++;
        if (ifc_rx16.busy !== 1'b0 || ifc_rx16.tx_line !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_rx16 busy=%b tx=%b expected busy=0 tx=1", ifc_rx16.busy, ifc_rx16.tx_line);
        end
    endtask

    task automatic test_tx_55();
        int k;
        ifc_tx.rw = 1'b0; ifc_tx.databus = 8'h55; ifc_tx.rx_line = 1'b1;
        rst_tx = 1'b0;
        step();
        rst_tx = 1'b1;
        for (int n = 0; n < 33; n++) begin
            k = n % 11;
            n_checks++;
            if (ifc_tx.tx_line !== exp_tx(8'h55, k)) begin
                n_errors++;
                $display("FAIL tx55_line n=%0d got %b expected %b", n, ifc_tx.tx_line, exp_tx(8'h55, k));
            end
            n_checks++;
            if (ifc_tx.busy !== (k != 0)) begin
                n_errors++;
                $display("FAIL tx55_busy n=%0d got %b expected %b", n, ifc_tx.busy, (k != 0));
            end
            step();
        end
    endtask

    // Random bytes; databus is scribbled and rw flipped to RX mid-frame,
    // with Rx held low, to show that neither is looked at outside IDLE.
    task automatic test_tx_random();
        logic [7:0] b;
        rst_tx = 1'b0;
        step();
        rst_tx = 1'b1;
        for (int f = 0; f < 6; f++) begin
            b = 8'($urandom);
            for (int k = 0; k < 11; k++) begin
                if (k == 0) begin
                    ifc_tx.rw = 1'b0; ifc_tx.rx_line = 1'b1; ifc_tx.databus = b;
                end
                n_checks++;
                if (ifc_tx.tx_line !== exp_tx(b, k)) begin
                    n_errors++;
                    $display("FAIL txrnd_line frame=%0d k=%0d byte=%h got %b expected %b",
                             f, k, b, ifc_tx.tx_line, exp_tx(b, k));
                end
                if (k == 3) ifc_tx.databus = ~b;
                if (k == 5) begin
                    ifc_tx.rw = 1'b1; ifc_tx.rx_line = 1'b0;
                end
                step();
            end
        end
        ifc_tx.rw = 1'b0; ifc_tx.rx_line = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = 8'($urandom) & 8'hF7;
        b2 = 8'($urandom);
        ifc_tx.rw = 1'b0; ifc_tx.databus = b1;
        rst_tx = 1'b0;
        step();
        rst_tx = 1'b1;
        repeat (5) step();
        n_checks++;
        if (ifc_tx.tx_line !== 1'b0 || ifc_tx.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_bit3 tx=%b busy=%b expected tx=0 busy=1", ifc_tx.tx_line, ifc_tx.busy);
        end
        #2 rst_tx = 1'b0;
        #1;
        n_checks++;
        if (ifc_tx.tx_line !== 1'b1 || ifc_tx.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_abort tx=%b busy=%b expected tx=1 busy=0", ifc_tx.tx_line, ifc_tx.busy);
        end
        repeat (2) step();
        ifc_tx.databus = b2;
        rst_tx = 1'b1;
        for (int n = 0; n < 12; n++) begin
            n_checks++;
            if (ifc_tx.tx_line !== exp_tx(b2, n % 11)) begin
                n_errors++;
                $display("FAIL midrst_reframe n=%0d got %b expected %b", n, ifc_tx.tx_line, exp_tx(b2, n % 11));
            end
            step();
        end
    endtask

    task automatic test_loopback();
        int  frames;
        bit  rx_tx_high;
        frames = 4;
        rx_tx_high = 1'b1;
        loop_en = 1'b1;
        ifc_tx.rw = 1'b0; ifc_tx.databus = 8'hA3;
        ifc_rx.rw = 1'b1;
        rst_tx = 1'b0; rst_rx = 1'b0;
        step();
        rst_tx = 1'b1; rst_rx = 1'b1;
        obs_q.delete();
        for (int c = 0; c < 11 * frames + 5; c++) begin
            step();
            if (ifc_rx.rx_valid === 1'b1) obs_q.push_back(ifc_rx.rx_data);
            if (ifc_rx.tx_line !== 1'b1) rx_tx_high = 1'b0;
        end
        n_checks++;
        if (obs_q.size() != frames) begin
            n_errors++;
            $display("FAIL loop_count got %0d expected %0d", obs_q.size(), frames);
        end
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== 8'hA3) begin
                n_errors++; $display("FAIL loop_data idx=%0d got %h expected a3", i, obs_q[i]);
            end
        end
        n_checks++;
        if (!rx_tx_high) begin
            n_errors++; $display("FAIL loop_rx_tx_idle got low expected constant 1");
        end
        loop_en = 1'b0;
    endtask

    task automatic test_rx_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] last_good;
        bit         stop;
        ifc_rx.rw = 1'b1; ifc_rx.rx_line = 1'b1;
        rst_rx = 1'b0;
        step();
        rst_rx = 1'b1;
        last_good = 8'h00;
        wave_q.delete();
        obs_q.delete();
        wave_q.push_back(1'b1);
        for (int f = 0; f < 10; f++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            append_frame(b, stop, $urandom_range(1, 3));
            if (stop) begin
                exp_q.push_back(b);
                last_good = b;
            end
        end
        wave_q.push_back(1'b1);
        drive_wave(0, 1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rxrnd_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL rxrnd_data idx=%0d got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ifc_rx.rx_data !== last_good) begin
            n_errors++; $display("FAIL rxrnd_hold got %h expected %h", ifc_rx.rx_data, last_good);
        end
    endtask

    task automatic test_framing_error();
        obs_q.delete();
        append_frame(8'h5A, 1'b1, 2);
        append_frame(8'h3C, 1'b0, 2);
        drive_wave(0, 1);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_errors++; $display("FAIL frame_count got %0d expected 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== 8'h5A) begin
                n_errors++; $display("FAIL frame_good got %h expected 5a", obs_q[0]);
            end
        end
        n_checks++;
        if (ifc_rx.rx_data !== 8'h5A) begin
            n_errors++; $display("FAIL frame_hold got %h expected 5a", ifc_rx.rx_data);
        end
    endtask

    task automatic test_glitch16();
        bit settled;
        bit strobed;
        settled = 1'b0;
        strobed = 1'b0;
        ifc_rx16.rw = 1'b1; ifc_rx16.rx_line = 1'b1;
        rst_rx16 = 1'b0;
        step();
        rst_rx16 = 1'b1;
        repeat (3) step();
        ifc_rx16.rx_line = 1'b0;
        repeat (4) step();
        n_checks++;
        if (ifc_rx16.busy !== 1'b1) begin
            n_errors++; $display("FAIL glitch_detect busy got %b expected 1", ifc_rx16.busy);
        end
        ifc_rx16.rx_line = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            if (ifc_rx16.rx_valid === 1'b1) strobed = 1'b1;
            if (ifc_rx16.busy === 1'b0) settled = 1'b1;
        end
        n_checks++;
        if (!settled || ifc_rx16.busy !== 1'b0) begin
            n_errors++; $display("FAIL glitch_idle busy got %b expected 0 within 16 clks", ifc_rx16.busy);
        end
        n_checks++;
        if (strobed || ifc_rx16.rx_data !== 8'h00) begin
            n_errors++;
            $display("FAIL glitch_nodata strobe=%b data=%h expected no strobe data 00", strobed, ifc_rx16.rx_data);
        end
    endtask

    task automatic test_rx16_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit         stop;
        obs_q.delete();
        for (int f = 0; f < 4; f++) begin
            b = 8'($urandom);
            stop = (f == 0) || ($urandom_range(0, 2) != 0);
            append_frame(b, stop, $urandom_range(1, 2));
            if (stop) exp_q.push_back(b);
        end
        drive_wave(1, 16);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rx16_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL rx16_data idx=%0d got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_tx = 1'b0; rst_rx = 1'b0; rst_rx16 = 1'b0;
        loop_en = 1'b0;
        test_reset();
        test_tx_55();
        test_tx_random();
        test_reset_mid_frame();
        test_loopback();
        test_rx_random();
        test_framing_error();
        test_glitch16();
        test_rx16_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
